bcd_serial_addsub: RTL and testbench

//  - Multi-digit packed-BCD add/subtract engine; one decimal digit processed per clock, LSD first.
//  - Consumes packed digit words and produces the decimal-adjusted packed result plus carry/borrow.
//  - Feeds the downstream digit-pair packing/output stage.
//  - valid/ready on both sides; one transaction in flight, no overlap.

---
 rtl/bcd_serial_addsub.sv | 134 +++++++++++++
 tb/tb_bcd_serial_addsub.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one decimal digit per clock, LSD first.
// Optional BCD_INVALID_CHECK_EN adds the out_invalid flag for operand nibbles above 9.
//   state  | meaning
//   IDLE   | waiting for operands, in_ready high
//   RUN    | processing digit r_cnt
//   DONE   | result held until out_ready
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_a,
  input  logic [4*DIGITS-1:0]   in_b,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_res,
`ifdef BCD_INVALID_CHECK_EN
  output logic                  out_invalid,
`endif
  output logic                  out_carry
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int         CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  logic [1:0]          r_state;
  logic [4*DIGITS-1:0] r_a;
  logic [4*DIGITS-1:0] r_b;
  logic                r_sub;
  logic                r_c;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_res;

  logic [3:0] w_da;
  logic [3:0] w_db;
  logic [4:0] w_sum;
  logic [4:0] w_sum_adj;
  logic [5:0] w_dif;
  logic [5:0] w_dif_adj;
  logic [3:0] w_dig;
  logic       w_cout;

  assign w_da      = r_a[4*r_cnt +: 4];
  assign w_db      = r_b[4*r_cnt +: 4];
  assign w_sum     = {1'b0, w_da} + {1'b0, w_db} + {4'b0, r_c};
  assign w_sum_adj = w_sum + 5'd6;
  assign w_dif     = {2'b0, w_da} - {2'b0, w_db} - {5'b0, r_c};
  assign w_dif_adj = w_dif + 6'd10;

  // 4-bit truncation of the adjusted value also defines the result for non-BCD nibbles
  always_comb begin
    w_dig  = w_sum[3:0];
    w_cout = 1'b0;
    if (!r_sub) begin
      if (w_sum > 5'd9) begin
        w_dig  = w_sum_adj[3:0];
        w_cout = 1'b1;
      end
    end else begin
      w_dig = w_dif[3:0];
      if (w_dif[5]) begin
        w_dig  = w_dif_adj[3:0];
        w_cout = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_sub   <= in_sub;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res[4*r_cnt +: 4] <= w_dig;
          r_c                 <= w_cout;
          r_cnt               <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  logic r_inv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inv <= 1'b0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_inv <= 1'b0;
    end else if (r_state == S_RUN && (w_da > 4'd9 || w_db > 4'd9)) begin
      r_inv <= 1'b1;
    end
  end

  assign out_invalid = r_inv;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_res   = r_res;
  assign out_carry = r_c;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Randomized self-checking bench for bcd_serial_addsub (DIGITS=4) against a decimal-integer model.
// Build with BCD_INVALID_CHECK_EN defined to also exercise out_invalid.
module tb_bcd_serial_addsub;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [4*D-1:0] in_a;
  logic [4*D-1:0] in_b;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [4*D-1:0] out_res;
  logic          out_carry;
`ifdef BCD_INVALID_CHECK_EN
  logic          out_invalid;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [4*D-1:0] exp_res;
  logic           exp_carry;
  logic           exp_inv;

  bcd_serial_addsub #(.DIGITS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
`ifdef BCD_INVALID_CHECK_EN
    .out_invalid (out_invalid),
`endif
    .out_carry (out_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int bcd2int(input logic [4*D-1:0] v);
    int r = 0;
    int w = 1;
    for (int i = 0; i < D; i++) begin
      r += int'(v[4*i +: 4]) * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic logic [4*D-1:0] int2bcd(input int v);
    logic [4*D-1:0] r = '0;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic any_bad(input logic [4*D-1:0] a, input logic [4*D-1:0] b);
    logic bad = 1'b0;
    for (int i = 0; i < D; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Whole-number decimal arithmetic modulo 10^D
  task automatic model(input logic [4*D-1:0] a, input logic [4*D-1:0] b, input logic s,
                       output logic [4*D-1:0] r, output logic c);
    int lim = 10 ** D;
    int v;
    if (!s) begin
      v = bcd2int(a) + bcd2int(b);
      c = (v >= lim);
      if (c) v -= lim;
    end else begin
      v = bcd2int(a) - bcd2int(b);
      c = (v < 0);
      if (c) v += lim;
    end
    r = int2bcd(v);
  endtask

  function automatic logic [4*D-1:0] rand_bcd();
    logic [4*D-1:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic junk_inputs(input logic allow_valid);
    in_valid = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    in_sub   = 1'($urandom_range(0, 1));
  endtask

  // lit_only: expectation comes solely from the literal (used for non-BCD operands)
  task automatic run_txn(input logic [4*D-1:0] a, input logic [4*D-1:0] b, input logic s,
                         input int hold, input logic use_lit, input logic lit_only,
                         input logic [4*D-1:0] lres, input logic lc, input string name);
    logic [4*D-1:0] mres;
    logic           mc;
    int             cyc;
    model(a, b, s, mres, mc);
    if (use_lit && !lit_only) begin
      chk({name, "_model_res"}, 32'(mres), 32'(lres));
      chk({name, "_model_carry"}, 32'(mc), 32'(lc));
    end
    exp_res   = lit_only ? lres : mres;
    exp_carry = lit_only ? lc : mc;
    exp_inv   = any_bad(a, b);
    chk({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      junk_inputs(1'b1);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    chk({name, "_latency"}, 32'(cyc), 32'(D));
    if (use_lit) begin
      chk({name, "_res"}, 32'(out_res), 32'(lres));
      chk({name, "_carry"}, 32'(out_carry), 32'(lc));
    end
    repeat (hold) begin
      junk_inputs(1'b1);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("mon_res", 32'(out_res), 32'(exp_res));
      chk("mon_carry", 32'(out_carry), 32'(exp_carry));
      chk("mon_in_ready_busy", 32'(in_ready), 32'd0);
`ifdef BCD_INVALID_CHECK_EN
      chk("mon_invalid", 32'(out_invalid), 32'(exp_inv));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    exp_res = '0; exp_carry = 1'b0; exp_inv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(out_res), 32'd0);
    chk("rst_carry", 32'(out_carry), 32'd0);
`ifdef BCD_INVALID_CHECK_EN
    chk("rst_invalid", 32'(out_invalid), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(16'h1234, 16'h5678, 1'b0, 0, 1'b1, 1'b0, 16'h6912, 1'b0, "add_basic");
    run_txn(16'h9999, 16'h0001, 1'b0, 1, 1'b1, 1'b0, 16'h0000, 1'b1, "add_carry");
    run_txn(16'h5000, 16'h1234, 1'b1, 0, 1'b1, 1'b0, 16'h3766, 1'b0, "sub_basic");
    run_txn(16'h0000, 16'h0001, 1'b1, 2, 1'b1, 1'b0, 16'h9999, 1'b1, "sub_borrow");
    run_txn(16'h4821, 16'h0379, 1'b0, 5, 1'b1, 1'b0, 16'h5200, 1'b0, "backpressure");

    // reset sampled at the second RUN edge drops the transaction
    in_a = 16'h8765; in_b = 16'h4321; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_res", 32'(out_res), 32'd0);
    chk("midrst_carry", 32'(out_carry), 32'd0);
    run_txn(16'h0001, 16'h0001, 1'b0, 0, 1'b1, 1'b0, 16'h0002, 1'b0, "after_rst");

    // non-BCD nibble: 15+1=16 -> (16+6)&15 = 6 with carry into the tens digit
    run_txn(16'h000F, 16'h0001, 1'b0, 0, 1'b1, 1'b1, 16'h0016, 1'b0, "nibble_f");
`ifdef BCD_INVALID_CHECK_EN
    run_txn(16'h00A0, 16'h0000, 1'b0, 1, 1'b1, 1'b1, 16'h0100, 1'b0, "inv_set");
    chk("inv_flag_set", 32'(exp_inv), 32'd1);
    run_txn(16'h0001, 16'h0001, 1'b0, 1, 1'b1, 1'b0, 16'h0002, 1'b0, "inv_clear");
`endif

    for (int t = 0; t < 60; t++) begin
      run_txn(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              1'b0, 1'b0, 16'h0000, 1'b0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
